// File: rtl/cpu_pkg.sv
// Shared constants for the 16-bit CPU front end.
// Holds the instruction field positions and the fetch state encoding.
package cpu_pkg;

    localparam int INSTR_W = 16;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 8;
    localparam int RS_HI  = 7;
    localparam int RS_LO  = 4;
    localparam int IMM_HI = 3;
    localparam int IMM_LO = 0;

    localparam logic [3:0] HALT_OPCODE = 4'hF;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_VALID = 2'd1,
        S_HALT  = 2'd2,
        S_FAULT = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_timeout_counter.sv
// Counts REQ cycles spent waiting for memAck.
// The expired flag marks the last cycle the fetch may still complete.
module fetch_timeout_counter #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam logic [7:0] TERM_CNT = 8'(TIMEOUT - 1);

    logic [7:0] r_wait_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_wait_cnt <= 8'd0;
        end else if (i_en) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end

    assign o_expired = (r_wait_cnt == TERM_CNT);

endmodule

// File: rtl/instruction_fetch.sv
// Fetch/decode-front stage: PC, memory request handshake and instruction register.
// Decoded fields are plain slices of the IR; imm4 feeds the sign extender.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   S_REQ   | memReq high, waiting for memAck at address pc
//   S_VALID | IR holds an instruction not yet consumed
//   S_HALT  | HALT opcode consumed; only rst leaves
//   S_FAULT | memory did not answer in TIMEOUT cycles; sticky
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [3:0]        HALT_OP  = HALT_OPCODE,
    parameter int                TIMEOUT  = 15
) (
    input  logic                clk,
    input  logic                rst,
    output logic                memReq,
    output logic [ADDR_W-1:0]   memAddr,
    input  logic                memAck,
    input  logic [INSTR_W-1:0]  memData,
    output logic                instrValid,
    input  logic                instrReady,
    output logic [3:0]          opcode,
    output logic [3:0]          rd,
    output logic [3:0]          rs,
    output logic [3:0]          imm4,
    input  logic                pcLoad,
    input  logic [ADDR_W-1:0]   pcTarget,
    output logic [ADDR_W-1:0]   pc,
    output logic                halted,
    output logic                fault
);

    fetch_state_e        r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [INSTR_W-1:0]  r_ir;
    logic                r_mem_req;
    logic                r_instr_valid;
    logic                r_halted;
    logic                r_fault;

    logic                w_cnt_clr;
    logic                w_cnt_en;
    logic                w_expired;

    // The wait counter only runs in REQ and restarts whenever a fetch ends or is redirected.
    assign w_cnt_en  = (r_state == S_REQ);
    assign w_cnt_clr = (r_state != S_REQ) || pcLoad || memAck;

    fetch_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_cnt_clr),
        .i_en      (w_cnt_en),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_REQ;
            r_pc          <= RESET_PC;
            r_ir          <= '0;
            r_mem_req     <= 1'b1;
            r_instr_valid <= 1'b0;
            r_halted      <= 1'b0;
            r_fault       <= 1'b0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (pcLoad) begin
                        r_pc <= pcTarget;
                    end else if (memAck) begin
                        r_ir          <= memData;
                        r_pc          <= r_pc + ADDR_W'(1);
                        r_state       <= S_VALID;
                        r_mem_req     <= 1'b0;
                        r_instr_valid <= 1'b1;
                    end else if (w_expired) begin
                        r_state   <= S_FAULT;
                        r_mem_req <= 1'b0;
                        r_fault   <= 1'b1;
                    end
                end
                S_VALID: begin
                    // Redirect consumes the instruction without looking at its opcode.
                    if (pcLoad) begin
                        r_pc          <= pcTarget;
                        r_state       <= S_REQ;
                        r_mem_req     <= 1'b1;
                        r_instr_valid <= 1'b0;
                    end else if (instrReady) begin
                        r_instr_valid <= 1'b0;
                        if (r_ir[OPC_HI:OPC_LO] == HALT_OP) begin
                            r_state  <= S_HALT;
                            r_halted <= 1'b1;
                        end else begin
                            r_state   <= S_REQ;
                            r_mem_req <= 1'b1;
                        end
                    end
                end
                S_HALT:  r_state <= S_HALT;
                S_FAULT: r_state <= S_FAULT;
                default: r_state <= S_FAULT;
            endcase
        end
    end

    assign memReq     = r_mem_req;
    assign memAddr    = r_pc;
    assign pc         = r_pc;
    assign instrValid = r_instr_valid;
    assign halted     = r_halted;
    assign fault      = r_fault;

    assign opcode = r_ir[OPC_HI:OPC_LO];
    assign rd     = r_ir[RD_HI:RD_LO];
    assign rs     = r_ir[RS_HI:RS_LO];
    assign imm4   = r_ir[IMM_HI:IMM_LO];

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios with literal checks, plus a
// cycle-by-cycle comparison against a behavioural model of the fetch rules.
module tb_instruction_fetch;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        memReq;
    logic [7:0]  memAddr;
    logic        memAck;
    logic [15:0] memData;
    logic        instrValid;
    logic        instrReady;
    logic [3:0]  opcode, rd, rs, imm4;
    logic        pcLoad;
    logic [7:0]  pcTarget;
    logic [7:0]  pc;
    logic        halted;
    logic        fault;

    int n_compared = 0;
    int n_mismatch = 0;

    always #5 clk = ~clk;

    instruction_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .memReq     (memReq),
        .memAddr    (memAddr),
        .memAck     (memAck),
        .memData    (memData),
        .instrValid (instrValid),
        .instrReady (instrReady),
        .opcode     (opcode),
        .rd         (rd),
        .rs         (rs),
        .imm4       (imm4),
        .pcLoad     (pcLoad),
        .pcTarget   (pcTarget),
        .pc         (pc),
        .halted     (halted),
        .fault      (fault)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatch++;
            $display("FAIL %s at %0t: got %h, required %h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: an instruction is either held or being requested,
    // unless the fetch unit has stopped for good (halted or faulted).
    bit          m_init = 0;
    bit          m_holding, m_stopped_halt, m_stopped_fault;
    logic [7:0]  m_pc;
    logic [15:0] m_ir;
    int          m_cycles_waited;

    always @(posedge clk) begin
        if (rst) begin
            m_init = 1;
            m_holding = 0; m_stopped_halt = 0; m_stopped_fault = 0;
            m_pc = 8'h00; m_ir = 16'h0000; m_cycles_waited = 0;
        end else if (m_init && !m_stopped_halt && !m_stopped_fault) begin
            if (!m_holding) begin
                if (pcLoad) begin
                    m_pc = pcTarget;
                    m_cycles_waited = 0;
                end else if (memAck) begin
                    m_ir = memData;
                    m_pc = m_pc + 8'd1;
                    m_holding = 1;
                    m_cycles_waited = 0;
                end else if (m_cycles_waited + 1 >= TIMEOUT) begin
                    m_stopped_fault = 1;
                end else begin
                    m_cycles_waited++;
                end
            end else if (pcLoad) begin
                m_pc = pcTarget;
                m_holding = 0;
            end else if (instrReady) begin
                m_holding = 0;
                if (m_ir[15:12] == 4'hF) m_stopped_halt = 1;
            end
        end
        #1;
        if (m_init) begin
            check("mdl_memReq", 16'(memReq),
                  16'(!m_holding && !m_stopped_halt && !m_stopped_fault));
            check("mdl_memAddr", 16'(memAddr), 16'(m_pc));
            check("mdl_pc", 16'(pc), 16'(m_pc));
            check("mdl_instrValid", 16'(instrValid), 16'(m_holding));
            check("mdl_fields", {opcode, rd, rs, imm4}, m_ir);
            check("mdl_halted", 16'(halted), 16'(m_stopped_halt));
            check("mdl_fault", 16'(fault), 16'(m_stopped_fault));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic idle_inputs();
        memAck = 0; memData = 16'h0000; instrReady = 0; pcLoad = 0; pcTarget = 8'h00;
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        tick(2);
        rst = 0;
        check("reset_memReq", 16'(memReq), 16'h1);
        check("reset_pc", 16'(pc), 16'h0);
        check("reset_valid", 16'(instrValid), 16'h0);
        check("reset_ir", {opcode, rd, rs, imm4}, 16'h0000);

        // Basic fetch, ack in the first REQ cycle
        memAck = 1; memData = 16'h1234; instrReady = 1;
        tick(1);
        memAck = 0;
        check("basic_valid", 16'(instrValid), 16'h1);
        check("basic_opcode", 16'(opcode), 16'h1);
        check("basic_rd", 16'(rd), 16'h2);
        check("basic_rs", 16'(rs), 16'h3);
        check("basic_imm4", 16'(imm4), 16'h4);
        check("basic_pc", 16'(pc), 16'h1);
        tick(1);
        check("basic_valid_drop", 16'(instrValid), 16'h0);
        check("basic_next_addr", 16'(memAddr), 16'h1);
        check("basic_next_req", 16'(memReq), 16'h1);

        // Stall in VALID; stray memAck while not requesting is ignored
        instrReady = 0; memAck = 1; memData = 16'h2345;
        tick(1);
        memData = 16'hBEEF;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("stall_valid", 16'(instrValid), 16'h1);
            check("stall_memReq", 16'(memReq), 16'h0);
            check("stall_ir", {opcode, rd, rs, imm4}, 16'h2345);
        end
        memAck = 0; instrReady = 1;
        tick(1);
        instrReady = 0;
        check("stall_release_req", 16'(memReq), 16'h1);
        check("stall_release_addr", 16'(memAddr), 16'h2);

        // Redirect colliding with memAck
        pcLoad = 1; pcTarget = 8'h05;
        tick(1);
        check("redir_pc5", 16'(pc), 16'h5);
        memAck = 1; memData = 16'hABCD; pcTarget = 8'h40;
        tick(1);
        idle_inputs();
        check("collide_pc", 16'(pc), 16'h40);
        check("collide_addr", 16'(memAddr), 16'h40);
        check("collide_valid", 16'(instrValid), 16'h0);
        check("collide_ir", {opcode, rd, rs, imm4}, 16'h2345);

        // Redirect with instrReady on a HALT word: consumed, no halt
        memAck = 1; memData = 16'hF00D;
        tick(1);
        memAck = 0; instrReady = 1; pcLoad = 1; pcTarget = 8'h20;
        tick(1);
        idle_inputs();
        check("redir_halt_skip", 16'(halted), 16'h0);
        check("redir_valid_pc", 16'(pc), 16'h20);

        // Halt
        memAck = 1; memData = 16'hF000; instrReady = 1;
        tick(1);
        memAck = 0;
        check("halt_fetch_opc", 16'(opcode), 16'hF);
        tick(1);
        check("halt_halted", 16'(halted), 16'h1);
        check("halt_memReq", 16'(memReq), 16'h0);
        memAck = 1; memData = 16'h5555; pcLoad = 1; pcTarget = 8'h77;
        tick(3);
        idle_inputs();
        check("halt_sticky", 16'(halted), 16'h1);
        check("halt_pc_hold", 16'(pc), 16'h21);
        check("halt_ir_hold", {opcode, rd, rs, imm4}, 16'hF000);
        rst = 1;
        tick(1);
        rst = 0;
        check("halt_rst_pc", 16'(pc), 16'h0);
        check("halt_rst_halted", 16'(halted), 16'h0);

        // Timeout: exactly TIMEOUT request cycles, then fault
        for (int i = 0; i < TIMEOUT; i++) begin
            check("timeout_req_window", 16'(memReq), 16'h1);
            tick(1);
        end
        check("timeout_fault", 16'(fault), 16'h1);
        check("timeout_memReq", 16'(memReq), 16'h0);
        pcLoad = 1; pcTarget = 8'h33; memAck = 1;
        tick(2);
        idle_inputs();
        check("fault_sticky", 16'(fault), 16'h1);
        check("fault_pc_hold", 16'(pc), 16'h0);
        rst = 1;
        tick(1);
        rst = 0;
        check("fault_rst", 16'(fault), 16'h0);

        // Ack in the last allowed cycle completes normally
        tick(TIMEOUT - 1);
        memAck = 1; memData = 16'h0123;
        tick(1);
        memAck = 0;
        check("late_ack_valid", 16'(instrValid), 16'h1);
        check("late_ack_fault", 16'(fault), 16'h0);
        instrReady = 1;
        tick(1);
        instrReady = 0;

        // PC wrap and reset mid-REQ
        pcLoad = 1; pcTarget = 8'hFF;
        tick(1);
        pcLoad = 0; memAck = 1; memData = 16'h1111;
        tick(1);
        memAck = 0;
        check("wrap_pc", 16'(pc), 16'h0);
        instrReady = 1;
        tick(1);
        instrReady = 0;
        check("wrap_addr", 16'(memAddr), 16'h0);
        pcLoad = 1; pcTarget = 8'h9A;
        tick(1);
        pcLoad = 0;
        tick(2);
        rst = 1;
        tick(1);
        rst = 0;
        check("midreq_rst_pc", 16'(pc), 16'h0);
        check("midreq_rst_req", 16'(memReq), 16'h1);
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch/decode-front stage of the 16-bit CPU.
- Requests instruction words from instruction memory over a req/ack handshake and holds the word in an instruction register (IR).
- Presents decoded fields to downstream logic. Field `imm4` drives the `data` input of the sign extender, which produces the 16-bit immediate operand.
- Owns the program counter. Supports redirect (branch/jump), halt, and a memory-timeout fault.

Parameters:
- ADDR_W, 8, program counter and memory address width.
- RESET_PC, 0, PC value loaded on reset.
- HALT_OP, 4'hF, opcode that halts fetch once it is consumed.
- TIMEOUT, 15, maximum cycles in REQ without memAck before fault; range 1..255.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- memReq  output  1  fetch request to instruction memory.
- memAddr  output  ADDR_W  fetch address; always equals pc.
- memAck  input  1  memory returns valid memData this cycle.
- memData  input  16  instruction word.
- instrValid  output  1  IR holds an undelivered instruction.
- instrReady  input  1  consumer accepts the instruction.
- opcode  output  4  IR[15:12].
- rd  output  4  IR[11:8].
- rs  output  4  IR[7:4].
- imm4  output  4  IR[3:0]; rt / immediate field, feeds the sign extender.
- pcLoad  input  1  redirect request.
- pcTarget  input  ADDR_W  redirect address.
- pc  output  ADDR_W  current fetch PC.
- halted  output  1  HALT state.
- fault  output  1  FAULT state (memory timeout).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=REQ, pc=RESET_PC, IR=16'h0000, waitCnt=0. instrValid, halted and fault are 0. memReq is 1 in the first cycle after reset because the reset state is REQ.
- States are REQ, VALID, HALT and FAULT. The encoding constants live in the package.
- REQ:
  - memReq=1, memAddr=pc, instrValid=0.
  - If memAck: IR<=memData, pc<=pc+1, waitCnt<=0, next state VALID.
  - Else if waitCnt==TIMEOUT-1: next state FAULT.
  - Else: waitCnt<=waitCnt+1.
- VALID:
  - instrValid=1, memReq=0. IR and the field outputs are stable.
  - If instrReady: opcode==HALT_OP goes to HALT; any other opcode goes to REQ.
  - Else hold in VALID indefinitely.
- HALT: halted=1, memReq=0, instrValid=0. Only rst leaves this state.
- FAULT: fault=1, memReq=0, instrValid=0. Sticky until rst.
- Latency:
  - If memAck arrives in the first REQ cycle, instrValid is 1 on the next cycle.
  - With instrReady tied high, throughput is one instruction per 2 cycles.
- PC arithmetic: unsigned ADDR_W-bit increment; (2^ADDR_W)-1 wraps to 0.
- Redirect:
  - pcLoad takes priority over every other event in REQ and VALID.
  - Effect: pc<=pcTarget, waitCnt<=0, next state REQ, instrValid=0 next cycle.
  - pcLoad with memAck in the same REQ cycle: the fetched word is discarded, IR is unchanged and pc takes pcTarget rather than pc+1.
  - pcLoad with instrReady in the same VALID cycle: the instruction counts as consumed and no HALT check is made. pc still takes pcTarget.
  - pcLoad is ignored in HALT and FAULT.
- Memory protocol: memAck while memReq=0 is ignored.
- Reset mid-operation: rst overrides every input in every state and restores all reset values on the next edge. Any outstanding fetch is abandoned.
- The field outputs are continuous slices of IR and are not gated by instrValid.

Decomposition:
- Shared package cpu_pkg:
  - Instruction width constant (16).
  - Field position constants (OPC_HI/LO, RD_HI/LO, RS_HI/LO, IMM_HI/LO).
  - HALT opcode constant.
  - Fetch state encodings: REQ, VALID, HALT, FAULT.
- One sub-module, fetch_timeout_counter: waitCnt with clear, enable and an expired flag.
- The FSM, PC and IR stay in instruction_fetch.

Test Plan:
- Basic fetch: reset with RESET_PC=0; memory returns 16'h1234 with memAck in the first REQ cycle; instrReady=1. Required: opcode=1, rd=2, rs=3, imm4=4; instrValid high for exactly 1 cycle; pc=1; the next request has memAddr=1.
- Stall: hold instrReady=0 for 5 cycles while in VALID. Required: instrValid and IR stay stable and memReq=0. On the first instrReady=1, the next cycle is REQ with memAddr=pc.
- Redirect collision: in REQ with pc=5, assert memAck (memData=16'hABCD) and pcLoad with pcTarget=8'h40 in the same cycle. Required: IR is unchanged, pc=0x40, next memAddr=0x40, no instrValid pulse.
- Halt: fetch 16'hF000 and accept it. Required: halted=1 permanently, memReq=0. Further memAck and pcLoad have no effect; rst restores pc=0 and halted=0.
- Timeout: with TIMEOUT=15, never assert memAck. Required: memReq stays high for exactly 15 cycles, then fault=1 and memReq=0. Asserting memAck in the 15th cycle instead completes the fetch with no fault.
- Wrap: set pcTarget=8'hFF, then fetch once. Required: pc becomes 0, and rst in the middle of a REQ returns pc to RESET_PC.
